// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: loads a seed into an external free-running LFSR, lets it advance
// nsteps states, captures the state and returns it over valid/ready.
module lfsr_seq_ctrl #(
    parameter int               WIDTH        = 26,
    parameter int               CNT_W        = 16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 26'h0000001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] nsteps,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             seed_sub,
    output logic             err_lock,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_din,
    input  logic [WIDTH-1:0] lfsr_q
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, r_nsteps;
    logic [WIDTH-1:0] r_seed, r_result;
    logic             r_seed_sub, r_err_lock;
    logic             w_accept, w_lock, w_abort;

    assign w_accept  = r_state == IDLE && start;
    assign w_abort   = r_state != IDLE && abort;
    assign w_lock    = r_state == RUN && lfsr_q == '0;
    assign busy      = r_state != IDLE;
    assign out_valid = r_state == DONE;
    assign lfsr_load = r_state == LOAD;
    assign lfsr_din  = r_seed;
    assign result    = r_result;
    assign seed_sub  = r_seed_sub;
    assign err_lock  = r_err_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = RUN;
            RUN:     w_next = w_lock ? LOAD : (r_cnt == '0 ? DONE : RUN);
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    // A lock-up restarts the whole job from DEFAULT_SEED with the original step count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed     <= '0;
            r_seed_sub <= 1'b0;
            r_cnt      <= '0;
            r_nsteps   <= '0;
            r_err_lock <= 1'b0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_seed     <= seed == '0 ? DEFAULT_SEED : seed;
            r_seed_sub <= seed == '0;
            r_cnt      <= nsteps;
            r_nsteps   <= nsteps;
            r_err_lock <= 1'b0;
        end else if (r_state == RUN && !abort) begin
            if (w_lock) begin
                r_err_lock <= 1'b1;
                r_seed     <= DEFAULT_SEED;
                r_cnt      <= r_nsteps;
            end else if (r_cnt == '0) begin
                r_result <= lfsr_q;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: drives random jobs through lfsr_seq_ctrl against a behavioural
// LFSR stub and compares results with a step-count reference model.
module tb_lfsr_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [25:0] seed = '0;
    logic [15:0] nsteps = '0;
    logic        abort = 1'b0;
    logic        busy, out_valid, seed_sub, err_lock, lfsr_load;
    logic        out_ready = 1'b0;
    logic [25:0] result, lfsr_din, lfsr_q;
    logic [25:0] r_q = 26'h1;
    logic        force_zero = 1'b0;
    int          load_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [25:0] last_res = '0;

    lfsr_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .nsteps(nsteps),
        .abort(abort), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .seed_sub(seed_sub), .err_lock(err_lock),
        .lfsr_load(lfsr_load), .lfsr_din(lfsr_din), .lfsr_q(lfsr_q)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] lfsr_next(input logic [25:0] s);
        return {s[24:0], s[25] ^ s[5] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [25:0] model(input logic [25:0] s, input int n);
        logic [25:0] v = s;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    always @(posedge clk) r_q <= lfsr_load ? lfsr_din : lfsr_next(r_q);
    assign lfsr_q = force_zero ? '0 : r_q;
    always @(posedge clk) if (lfsr_load === 1'b1) load_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_job(input logic [25:0] s, input logic [15:0] n, output int lat,
                          output logic ld, output logic [25:0] din);
        @(negedge clk); start = 1'b1; seed = s; nsteps = n;
        @(negedge clk); start = 1'b0; ld = lfsr_load; din = lfsr_din;
        lat = 0;
        while (out_valid !== 1'b1 && lat < int'(n) + 10) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, out_valid, lfsr_load, seed_sub, err_lock} !== 5'b0 || result !== '0 || lfsr_din !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b ov=%b ld=%b sub=%b err=%b res=%h din=%h want all 0",
                     busy, out_valid, lfsr_load, seed_sub, err_lock, result, lfsr_din);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_steps();
        int lat; logic ld; logic [25:0] din;
        do_job(26'h9E2, 16'd0, lat, ld, din);
        total++;
        if (ld !== 1'b1 || din !== 26'h9E2) begin
            bad++; $display("FAIL zero_steps_load: load=%b din=%h want 1 0009e2", ld, din);
        end
        total++;
        if (lat !== 2 || result !== 26'h9E2 || seed_sub !== 1'b0) begin
            bad++; $display("FAIL zero_steps_result: lat=%0d res=%h sub=%b want 2 0009e2 0", lat, result, seed_sub);
        end
        last_res = 26'h9E2;
        ack();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL zero_steps_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_steps();
        int lat, l0; logic ld; logic [25:0] din, s, exp; logic [15:0] n;
        for (int k = 0; k < 6; k++) begin
            s = k == 0 ? 26'h9E2 : 26'($urandom_range(1, 26'h3FFFFFF));
            n = k == 0 ? 16'd5 : 16'($urandom_range(1, 40));
            exp = model(s, int'(n));
            l0 = load_cnt;
            do_job(s, n, lat, ld, din);
            total++;
            if (lat !== int'(n) + 2 || result !== exp || load_cnt - l0 !== 1 || seed_sub !== 1'b0) begin
                bad++;
                $display("FAIL steps[%0d]: lat=%0d res=%h loads=%0d sub=%b want %0d %h 1 0",
                         k, lat, result, load_cnt - l0, seed_sub, int'(n) + 2, exp);
            end
            last_res = exp;
            ack();
        end
    endtask

    task automatic test_zero_seed();
        int lat; logic ld; logic [25:0] din;
        do_job(26'h0, 16'd3, lat, ld, din);
        total++;
        if (din !== 26'h1 || seed_sub !== 1'b1) begin
            bad++; $display("FAIL zero_seed_sub: din=%h sub=%b want 0000001 1", din, seed_sub);
        end
        total++;
        if (result !== model(26'h1, 3) || lat !== 5) begin
            bad++; $display("FAIL zero_seed_result: res=%h lat=%0d want %h 5", result, lat, model(26'h1, 3));
        end
        last_res = model(26'h1, 3);
        ack();
    endtask

    task automatic test_backpressure();
        int lat, l0; logic ld; logic [25:0] din, s, exp;
        s = 26'($urandom_range(1, 26'h3FFFFFF));
        exp = model(s, 4);
        do_job(s, 16'd4, lat, ld, din);
        l0 = load_cnt;
        for (int k = 0; k < 10; k++) begin
            start = k[0]; seed = 26'($urandom); nsteps = 16'd2;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== exp) begin
                bad++; $display("FAIL backpressure[%0d]: ov=%b res=%h want 1 %h", k, out_valid, result, exp);
            end
        end
        start = 1'b0;
        total++;
        if (load_cnt !== l0) begin bad++; $display("FAIL backpressure_start: loads=%0d want %0d", load_cnt, l0); end
        ack();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL backpressure_release: busy=%b ov=%b want 0 0", busy, out_valid);
        end
        s = 26'($urandom_range(1, 26'h3FFFFFF));
        do_job(s, 16'd6, lat, ld, din);
        total++;
        if (result !== model(s, 6) || lat !== 8) begin
            bad++; $display("FAIL backpressure_next: res=%h lat=%0d want %h 8", result, lat, model(s, 6));
        end
        last_res = model(s, 6);
        ack();
    endtask

    task automatic test_lockup();
        int lat, l0; logic ld; logic [25:0] din, s;
        s = 26'($urandom_range(1, 26'h3FFFFFF));
        l0 = load_cnt;
        @(negedge clk); start = 1'b1; seed = s; nsteps = 16'd8;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        force_zero = 1'b1;
        @(negedge clk); force_zero = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        total++;
        if (lat >= 40) begin bad++; $display("FAIL lockup_timeout: out_valid=%b want 1", out_valid); end
        total++;
        if (err_lock !== 1'b1 || load_cnt - l0 !== 2 || lfsr_din !== 26'h1) begin
            bad++; $display("FAIL lockup_flag: err=%b loads=%0d din=%h want 1 2 0000001", err_lock, load_cnt - l0, lfsr_din);
        end
        total++;
        if (result !== model(26'h1, 8)) begin
            bad++; $display("FAIL lockup_result: res=%h want %h", result, model(26'h1, 8));
        end
        ack();
        s = 26'($urandom_range(1, 26'h3FFFFFF));
        do_job(s, 16'd2, lat, ld, din);
        total++;
        if (err_lock !== 1'b0 || result !== model(s, 2)) begin
            bad++; $display("FAIL lockup_clear: err=%b res=%h want 0 %h", err_lock, result, model(s, 2));
        end
        last_res = model(s, 2);
        ack();
    endtask

    task automatic test_abort();
        int l0;
        @(negedge clk); start = 1'b1; seed = 26'($urandom_range(1, 26'h3FFFFFF)); nsteps = 16'd10;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        l0 = load_cnt;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== last_res) begin
            bad++; $display("FAIL abort: busy=%b ov=%b res=%h want 0 0 %h", busy, out_valid, result, last_res);
        end
        repeat (5) @(negedge clk);
        total++;
        if (load_cnt !== l0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_quiet: loads=%0d busy=%b want %0d 0", load_cnt, busy, l0);
        end
    endtask

    task automatic test_reset_mid();
        int l0, lat; logic ld; logic [25:0] din, s;
        @(negedge clk); start = 1'b1; seed = 26'($urandom_range(1, 26'h3FFFFFF)); nsteps = 16'd20;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || lfsr_load !== 1'b0 || result !== '0) begin
            bad++; $display("FAIL reset_mid: busy=%b ov=%b ld=%b res=%h want 0 0 0 0", busy, out_valid, lfsr_load, result);
        end
        @(negedge clk); rst_n = 1'b1;
        l0 = load_cnt;
        repeat (4) @(negedge clk);
        total++;
        if (load_cnt !== l0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_quiet: loads=%0d busy=%b want %0d 0", load_cnt, busy, l0);
        end
        s = 26'($urandom_range(1, 26'h3FFFFFF));
        do_job(s, 16'd7, lat, ld, din);
        total++;
        if (result !== model(s, 7) || lat !== 9) begin
            bad++; $display("FAIL reset_mid_next: res=%h lat=%0d want %h 9", result, lat, model(s, 7));
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_zero_steps();
        test_steps();
        test_zero_seed();
        test_backpressure();
        test_lockup();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
